// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide on one shared shift/add-subtract datapath.
// Operands are reduced to magnitudes at start; signs are reapplied in FIX before hi/lo are written.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_n;
  logic               load, load_zero;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res, neg_rem;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    load_zero = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          load      = 1'b1;
          load_zero = op[1] && (b == '0);
          state_n   = load_zero ? DONE : RUN;
        end
      end
      RUN:     if (cnt == LAST) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    // rem doubles as the running upper product half (multiply) and the partial remainder (divide)
    mul_sum  = {1'b0, rem[WIDTH-1:0]} + (q[0] ? {1'b0, mag_b} : '0);
    div_sh   = {rem[WIDTH-1:0], q[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_b};
    prod_fix = neg_res ? -{rem[WIDTH-1:0], q} : {rem[WIDTH-1:0], q};
    quot_fix = neg_res ? -q : q;
    rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      mag_b    <= '0;
      rem      <= '0;
      q        <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == RUN) || (state_n == FIX);
      done  <= (state_n == DONE);
      if (load) begin
        if (load_zero) begin
          hi       <= a;
          lo       <= '1;
          div_zero <= 1'b1;
        end else begin
          div_zero <= 1'b0;
          cnt      <= '0;
          is_div   <= op[1];
          neg_res  <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          mag_b    <= b_mag;
          rem      <= '0;
          q        <= a_mag;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          if (!div_diff[WIDTH]) begin
            rem <= div_diff;
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_sh;
            q   <= {q[WIDTH-2:0], 1'b0};
          end
        end else begin
          rem <= {1'b0, mul_sum[WIDTH:1]};
          q   <= {mul_sum[0], q[WIDTH-1:1]};
        end
      end else if (state == FIX) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule
